// File: rtl/mini_alu_pkg.sv
// rtl/mini_alu_pkg.sv - shared opcodes and instruction field helpers for mini_alu_pipe
// Purpose: opcode encodings, field offsets within {opc, dst, src1, src0}, NOP encoding.
// Ports: none (package).
package mini_alu_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_MUL = 4'd3;
  localparam logic [3:0] OP_STO = 4'd4;
  localparam logic [3:0] OP_BLE = 4'd5;
  localparam logic [3:0] OP_JMP = 4'd6;
  localparam logic [3:0] OP_OUT = 4'd7;
  localparam logic [3:0] OP_SHR = 4'd8;
  localparam logic [3:0] OP_SHL = 4'd9;
  localparam logic [3:0] OP_AND = 4'd10;
  localparam logic [3:0] OP_OR  = 4'd11;
  localparam logic [3:0] OP_BEQ = 4'd12;
  localparam logic [3:0] OP_HLT = 4'd15;

  // Field index, LSB first: src0, src1, dst, then the opcode on top.
  localparam int FLD_SRC0 = 0;
  localparam int FLD_SRC1 = 1;
  localparam int FLD_DST  = 2;
  localparam int FLD_OPC  = 3;

  function automatic int fieldLsb(input int addrW, input int fld);
    return fld * addrW;
  endfunction

  // An all-zero word decodes as NOP (opcode 0), so flushes just clear the register.
  localparam logic NOP_FILL = 1'b0;

endpackage

// File: rtl/mini_alu_regfile.sv
// rtl/mini_alu_regfile.sv - 2-read/1-write register array for mini_alu_pipe
// Purpose: 2**ADDR_W x DATA_W storage, combinational reads, posedge write. Not reset.
// Ports: clk; wrEn/wrAddr/wrData write port; rdAddr0/rdData0, rdAddr1/rdData1 read ports.
module mini_alu_regfile #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic [ADDR_W-1:0] rdAddr0,
  input  logic [ADDR_W-1:0] rdAddr1,
  output logic [DATA_W-1:0] rdData0,
  output logic [DATA_W-1:0] rdData1
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wrEn) mem[wrAddr] <= wrData;
  end

  assign rdData0 = mem[rdAddr0];
  assign rdData1 = mem[rdAddr1];

endmodule

// File: rtl/mini_alu_pipe.sv
// rtl/mini_alu_pipe.sv - 2-stage fetch/execute mini ALU core with ready/valid output
// Purpose: fetches from a combinational ROM at oIP, executes one instruction per cycle,
//   emits OUT words through a one-entry ready/valid register that back-pressures the pipe.
// Ports: Clock, Reset (sync, active-high); oIP/iInstruction ROM interface;
//   oOutData/oOutValid/iOutReady output stream; oHalted set by HLT.
module mini_alu_pipe
  import mini_alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int IP_W   = 16,
  parameter int OPC_W  = 4
) (
  input  logic                      Clock,
  input  logic                      Reset,
  output logic [IP_W-1:0]           oIP,
  input  logic [OPC_W+3*ADDR_W-1:0] iInstruction,
  output logic [DATA_W-1:0]         oOutData,
  output logic                      oOutValid,
  input  logic                      iOutReady,
  output logic                      oHalted
);

  localparam int INSTR_W = OPC_W + 3 * ADDR_W;
  localparam int SH_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [IP_W-1:0]    ipReg;
  logic [INSTR_W-1:0] feInstr;
  logic [DATA_W-1:0]  outData;
  logic               outValid;
  logic               halted;

  logic [OPC_W-1:0]  opc;
  logic [ADDR_W-1:0] dst, src1, src0;
  logic [DATA_W-1:0] rd0, rd1, result;
  logic              wrEn, branchTaken, isOut, isHlt, loadOut, stall;

  assign opc  = feInstr[fieldLsb(ADDR_W, FLD_OPC) +: OPC_W];
  assign dst  = feInstr[fieldLsb(ADDR_W, FLD_DST) +: ADDR_W];
  assign src1 = feInstr[fieldLsb(ADDR_W, FLD_SRC1) +: ADDR_W];
  assign src0 = feInstr[fieldLsb(ADDR_W, FLD_SRC0) +: ADDR_W];

  mini_alu_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) uRegfile (
    .clk     (Clock),
    .wrEn    (wrEn),
    .wrAddr  (dst),
    .wrData  (result),
    .rdAddr0 (src0),
    .rdAddr1 (src1),
    .rdData0 (rd0),
    .rdData1 (rd1)
  );

  always_comb begin
    result      = '0;
    wrEn        = 1'b0;
    branchTaken = 1'b0;
    isOut       = 1'b0;
    isHlt       = 1'b0;
    case (opc)
      OPC_W'(OP_ADD): begin result = rd1 + rd0; wrEn = 1'b1; end
      OPC_W'(OP_SUB): begin result = rd1 - rd0; wrEn = 1'b1; end
      OPC_W'(OP_MUL): begin result = rd1 * rd0; wrEn = 1'b1; end
      OPC_W'(OP_STO): begin result = DATA_W'({src1, src0}); wrEn = 1'b1; end
      OPC_W'(OP_BLE): branchTaken = ($signed(rd1) <= $signed(rd0));
      OPC_W'(OP_JMP): branchTaken = 1'b1;
      OPC_W'(OP_OUT): isOut = 1'b1;
      OPC_W'(OP_SHR): begin result = rd1 >> rd0[SH_W-1:0]; wrEn = 1'b1; end
      OPC_W'(OP_SHL): begin result = rd1 << rd0[SH_W-1:0]; wrEn = 1'b1; end
      OPC_W'(OP_AND): begin result = rd1 & rd0; wrEn = 1'b1; end
      OPC_W'(OP_OR):  begin result = rd1 | rd0; wrEn = 1'b1; end
      OPC_W'(OP_BEQ): branchTaken = (rd1 == rd0);
      OPC_W'(OP_HLT): isHlt = 1'b1;
      default: ;
    endcase
  end

  // The slot can take a word if it is empty or is being drained this very edge.
  assign loadOut = isOut && (!outValid || iOutReady);
  assign stall   = isOut && outValid && !iOutReady;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      ipReg    <= '0;
      feInstr  <= {INSTR_W{NOP_FILL}};
      outData  <= '0;
      outValid <= 1'b0;
      halted   <= 1'b0;
    end else begin
      if (loadOut) begin
        outData  <= rd1;
        outValid <= 1'b1;
      end else if (iOutReady) begin
        outValid <= 1'b0;
      end

      // Once halted, feInstr already holds NOP and the IP stays frozen.
      if (!halted) begin
        if (isHlt) begin
          halted  <= 1'b1;
          feInstr <= {INSTR_W{NOP_FILL}};
        end else if (stall) begin
          ipReg   <= ipReg;
          feInstr <= feInstr;
        end else if (branchTaken) begin
          // The sequentially fetched word in flight is squashed.
          ipReg   <= IP_W'(dst);
          feInstr <= {INSTR_W{NOP_FILL}};
        end else begin
          ipReg   <= ipReg + 1'b1;
          feInstr <= iInstruction;
        end
      end
    end
  end

  assign oIP       = ipReg;
  assign oOutData  = outData;
  assign oOutValid = outValid;
  assign oHalted   = halted;

endmodule

// File: tb/tb_mini_alu_pipe.sv
// tb/tb_mini_alu_pipe.sv - self-checking bench for mini_alu_pipe
module tb_mini_alu_pipe;

  typedef struct packed {
    logic [11:0][27:0] prog;
    int                nOut;
    logic [2:0][15:0]  exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        Reset;
  logic        ready;
  logic [15:0] ip;
  logic [27:0] instr;
  logic [15:0] data;
  logic        valid;
  logic        halted;
  logic [27:0] rom [256];

  logic [7:0]  ip2;
  logic [15:0] instr2;
  logic [7:0]  data2;
  logic        valid2;
  logic        halted2;
  logic [15:0] rom2 [256];

  assign instr  = rom[ip[7:0]];
  assign instr2 = rom2[ip2];

  mini_alu_pipe dut (
    .Clock(clk), .Reset(Reset), .oIP(ip), .iInstruction(instr),
    .oOutData(data), .oOutValid(valid), .iOutReady(ready), .oHalted(halted)
  );

  mini_alu_pipe #(.DATA_W(8), .ADDR_W(4), .IP_W(8), .OPC_W(4)) dutSmall (
    .Clock(clk), .Reset(Reset), .oIP(ip2), .iInstruction(instr2),
    .oOutData(data2), .oOutValid(valid2), .iOutReady(ready), .oHalted(halted2)
  );

  int checks = 0;
  int failures = 0;
  logic [15:0] got[$];
  vec_t vecs[8];

  function automatic logic [27:0] mk(input int opc, input int d, input int s1, input int s0);
    logic [31:0] o, dd, a, b;
    o = opc; dd = d; a = s1; b = s0;
    return {o[3:0], dd[7:0], a[7:0], b[7:0]};
  endfunction

  function automatic logic [27:0] sto(input int d, input int imm);
    return mk(4, d, (imm >> 8) & 255, imm & 255);
  endfunction

  function automatic logic [15:0] mk2(input int opc, input int d, input int s1, input int s0);
    logic [31:0] o, dd, a, b;
    o = opc; dd = d; a = s1; b = s0;
    return {o[3:0], dd[3:0], a[3:0], b[3:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doReset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  task automatic clearRoms();
    for (int i = 0; i < 256; i++) begin
      rom[i]  = '0;
      rom2[i] = '0;
    end
  endtask

  // Record words that will be accepted at the coming edge, then advance.
  task automatic collect(input int n);
    for (int i = 0; i < n; i++) begin
      if (valid && ready) got.push_back(data);
      tick();
    end
  endtask

  task automatic p(input int v, input int a, input logic [27:0] ins);
    vecs[v].prog[a] = ins;
  endtask

  task automatic e(input int v, input int n, input int w0, input int w1, input int w2);
    vecs[v].nOut   = n;
    vecs[v].exp[0] = w0[15:0];
    vecs[v].exp[1] = w1[15:0];
    vecs[v].exp[2] = w2[15:0];
  endtask

  task automatic loadVec(input int v);
    clearRoms();
    for (int a = 0; a < 12; a++) rom[a] = vecs[v].prog[a];
  endtask

  task automatic runVec(input int v);
    ready = 1'b1;
    loadVec(v);
    doReset();
    got.delete();
    collect(40);
    check($sformatf("v%0d_count", v), got.size(), vecs[v].nOut);
    for (int i = 0; i < vecs[v].nOut; i++)
      if (i < got.size()) check($sformatf("v%0d_word%0d", v, i), got[i], vecs[v].exp[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ipStable;
    Reset = 1'b1;
    ready = 1'b1;
    clearRoms();
    for (int i = 0; i < 8; i++) vecs[i] = '0;

    // 0: STO/STO/ADD/OUT
    p(0,0,sto(1,5)); p(0,1,sto(2,7)); p(0,2,mk(1,3,2,1)); p(0,3,mk(7,0,3,0));
    e(0,1,12,0,0);
    // 1: MUL wrap and SUB negative
    p(1,0,sto(1,16'h0100)); p(1,1,mk(3,2,1,1)); p(1,2,sto(4,3)); p(1,3,sto(5,5));
    p(1,4,mk(2,6,4,5)); p(1,5,mk(7,0,2,0)); p(1,6,mk(7,0,6,0));
    e(1,2,16'h0000,16'hFFFE,0);
    // 2: AND / OR
    p(2,0,sto(1,16'hF0F0)); p(2,1,sto(2,16'h3C3C)); p(2,2,mk(10,3,1,2)); p(2,3,mk(11,4,1,2));
    p(2,4,mk(7,0,3,0)); p(2,5,mk(7,0,4,0));
    e(2,2,16'h3030,16'hFCFC,0);
    // 3: shifts, amount taken from low 4 bits
    p(3,0,sto(1,16'h8001)); p(3,1,sto(2,4)); p(3,2,mk(8,3,1,2)); p(3,3,mk(9,4,1,2));
    p(3,4,sto(5,16'h0014)); p(3,5,mk(9,6,1,5)); p(3,6,mk(7,0,3,0)); p(3,7,mk(7,0,4,0));
    p(3,8,mk(7,0,6,0)); p(3,9,mk(15,0,0,0));
    e(3,3,16'h0800,16'h0010,16'h0010);
    // 4: BEQ taken, flushed and skipped writes
    p(4,0,sto(3,16'h22)); p(4,1,sto(1,9)); p(4,2,sto(2,9)); p(4,3,mk(12,6,1,2));
    p(4,4,sto(3,16'h11)); p(4,5,sto(3,16'h33)); p(4,6,mk(7,0,3,0)); p(4,7,mk(15,0,0,0));
    e(4,1,16'h22,0,0);
    // 5: BEQ not taken, BLE signed taken
    p(5,0,sto(3,16'h22)); p(5,1,sto(1,9)); p(5,2,sto(2,8)); p(5,3,mk(12,7,1,2));
    p(5,4,sto(3,16'h44)); p(5,5,mk(7,0,3,0)); p(5,6,sto(4,16'h8000)); p(5,7,mk(5,10,4,1));
    p(5,8,mk(7,0,4,0)); p(5,9,mk(7,0,1,0)); p(5,10,mk(7,0,2,0)); p(5,11,mk(15,0,0,0));
    e(5,2,16'h44,16'h0008,0);
    // 6: undefined opcodes behave as NOP, JMP
    p(6,0,sto(1,1)); p(6,1,mk(13,1,0,5)); p(6,2,mk(14,16'h30,0,0)); p(6,3,mk(7,0,1,0));
    p(6,4,mk(6,7,0,0)); p(6,5,mk(7,0,1,0)); p(6,6,mk(7,0,1,0)); p(6,7,sto(2,16'h77));
    p(6,8,mk(7,0,2,0)); p(6,9,mk(15,0,0,0));
    e(6,2,1,16'h77,0);
    // 7: BLE falls through (1 <= -2 false), then BLE equal taken
    p(7,0,sto(1,16'hFFFE)); p(7,1,sto(2,1)); p(7,2,sto(9,0)); p(7,3,mk(5,16'h20,2,1));
    p(7,4,sto(9,1)); p(7,5,mk(7,0,9,0)); p(7,6,mk(5,9,2,2)); p(7,7,mk(7,0,1,0));
    p(7,8,mk(7,0,1,0)); p(7,9,mk(7,0,2,0)); p(7,10,mk(15,0,0,0));
    e(7,2,1,1,0);

    // Reset state and first-output latency
    loadVec(0);
    doReset();
    check("rst_ip", ip, 0);
    check("rst_valid", valid, 0);
    check("rst_data", data, 0);
    check("rst_halted", halted, 0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("lat_valid_c%0d", k), valid, (k == 5) ? 1 : 0);
      if (k == 5) check("lat_data", data, 12);
    end

    for (int v = 0; v < 8; v++) runVec(v);

    // Taken BLE: redirect on the following cycle, R9 never written
    clearRoms();
    rom[0] = sto(1,16'hFFFE); rom[1] = sto(2,1); rom[2] = sto(9,0);
    rom[3] = mk(5,16'h20,1,2); rom[4] = sto(9,1);
    rom[16'h20] = mk(7,0,9,0); rom[16'h21] = mk(15,0,0,0);
    ready = 1'b1;
    doReset();
    repeat (4) tick();
    check("ble_ip_before", ip, 4);
    tick();
    check("ble_ip_target", ip, 16'h20);
    got.delete();
    collect(6);
    check("ble_count", got.size(), 1);
    if (got.size() > 0) check("ble_r9", got[0], 0);

    // Back-pressure stall and release
    clearRoms();
    rom[0] = sto(1,16'hA); rom[1] = sto(2,16'hB); rom[2] = mk(7,0,1,0); rom[3] = mk(7,0,2,0);
    rom[4] = sto(3,5); rom[5] = mk(7,0,3,0); rom[6] = mk(15,0,0,0);
    ready = 1'b0;
    doReset();
    repeat (4) tick();
    check("stall_first_valid", valid, 1);
    check("stall_first_data", data, 16'hA);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("stall_data_c%0d", k), data, 16'hA);
    end
    check("stall_ip", ip, 4);
    ready = 1'b1;
    got.delete();
    collect(2);
    check("stall_ip_resume", ip, 6);
    collect(6);
    check("stall_count", got.size(), 3);
    if (got.size() == 3) begin
      check("stall_w0", got[0], 16'hA);
      check("stall_w1", got[1], 16'hB);
      check("stall_w2", got[2], 5);
    end

    // HLT with a pending word, then reset clears the halt
    clearRoms();
    rom[0] = sto(1,16'h55); rom[1] = mk(7,0,1,0); rom[6] = mk(15,0,0,0);
    rom[7] = sto(1,16'h99); rom[8] = mk(7,0,1,0);
    ready = 1'b0;
    doReset();
    for (int k = 0; k < 20 && !halted; k++) tick();
    check("hlt_halted", halted, 1);
    check("hlt_ip", ip, 7);
    ipStable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (ip !== 16'd7) ipStable = 1'b0;
    end
    check("hlt_ip_frozen", ipStable, 1);
    check("hlt_pending_valid", valid, 1);
    check("hlt_pending_data", data, 16'h55);
    ready = 1'b1;
    got.delete();
    collect(3);
    check("hlt_drain_count", got.size(), 1);
    if (got.size() > 0) check("hlt_drain_word", got[0], 16'h55);
    check("hlt_drain_valid", valid, 0);
    check("hlt_still_halted", halted, 1);
    doReset();
    check("hlt_reset_halted", halted, 0);
    check("hlt_reset_ip", ip, 0);

    // Narrow instance: 8-bit data, 4-bit fields
    clearRoms();
    rom2[0] = mk2(4,1,4'hA,4'hB); rom2[1] = mk2(4,2,0,4); rom2[2] = mk2(9,3,1,2);
    rom2[3] = mk2(7,0,3,0); rom2[4] = mk2(15,0,0,0);
    ready = 1'b1;
    doReset();
    got.delete();
    for (int k = 0; k < 10; k++) begin
      if (valid2 && ready) got.push_back({8'h00, data2});
      tick();
    end
    check("small_count", got.size(), 1);
    if (got.size() > 0) check("small_shl", got[0], 16'h00B0);
    check("small_halted", halted2, 1);

    // IP wrap on the 8-bit-IP instance
    clearRoms();
    doReset();
    repeat (255) tick();
    check("wrap_ip_max", ip2, 8'hFF);
    tick();
    check("wrap_ip_zero", ip2, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
